alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, operand width of the ALU sub-units; results are 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 4, maximum WAIT cycles for a unit flag (>=1).
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  operation request.
REQ-006 req_fun  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] sub-function.
REQ-007 req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-008 UNIT_EN  output  4  one-hot unit enable; bit index = unit select.
REQ-009 ALU_FUN  output  2  sub-function to the selected unit.
REQ-010 UNIT_FLAG  input  4  per-unit result-valid flag; bit index = unit select.
REQ-011 ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT  input  2*WIDTH each  unit results, narrower units zero-extended upstream.
REQ-012 ALU_OUT  output  2*WIDTH  captured result of the last completed operation.
REQ-013 OUT_VALID  output  1  one-cycle pulse when ALU_OUT is updated.
REQ-014 TIMEOUT_ERR  output  1  one-cycle pulse when an operation is abandoned.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-016 IDLE: on acceptance at cycle T, the block SHALL latch the unit select and req_fun[1:0] and enter ISSUE at T+1.
REQ-017 ISSUE: UNIT_EN[sel] SHALL be 1 for exactly one cycle (T+1), with all other bits 0, and the FSM SHALL then enter WAIT.
REQ-018 ALU_FUN SHALL equal the latched sub-function from ISSUE through the last WAIT cycle, and SHALL hold its value in IDLE.
REQ-019 WAIT: when UNIT_FLAG[sel]=1, the block SHALL register the selected unit output into ALU_OUT, pulse OUT_VALID on the next cycle, and return to IDLE.
REQ-020 For a 1-cycle unit (flag at T+2), OUT_VALID SHALL be high at T+3 and req_ready SHALL be high at T+3.
REQ-021 UNIT_FLAG bits other than sel, and all flags outside WAIT, SHALL be ignored.
REQ-022 A WAIT-cycle counter SHALL be 0 on the first WAIT cycle; if the counter equals TIMEOUT-1 and the flag is absent, the block SHALL pulse TIMEOUT_ERR on the next cycle, leave ALU_OUT unchanged, keep OUT_VALID at 0, and return to IDLE.
REQ-023 If the flag arrives in the same cycle that the counter reaches TIMEOUT-1, the flag SHALL win: OUT_VALID is asserted and no error is raised.
REQ-024 OUT_VALID and TIMEOUT_ERR SHALL never be high in the same cycle.
REQ-025 req_ready SHALL be a combinational decode of state == IDLE.

Reset
REQ-026 While RST=1 at a clock edge, the block SHALL go to IDLE and set UNIT_EN=0, ALU_FUN=0, ALU_OUT=0, OUT_VALID=0, TIMEOUT_ERR=0 and the counter to 0.
REQ-027 Reset asserted mid-ISSUE or mid-WAIT SHALL abort the operation with no later capture; a flag arriving after reset SHALL be ignored.

Structure
REQ-028 The shared package alu_pkg SHALL hold the state encoding, the unit-select constants (UNIT_ARITH=2'b00, UNIT_LOGIC=2'b01, UNIT_CMP=2'b10, UNIT_SHIFT=2'b11) and the result-width function.
REQ-029 The WAIT watchdog SHALL be a single sub-module, alu_seq_timer (inputs clear and run; output expired), and there SHALL be no other sub-modules.

Verification (WIDTH=16, TIMEOUT=4, acceptance at T)
REQ-030 Shift: req_fun=4'b1101, unit model raises flag at T+2 with SHIFT_OUT=0x00004A52 -> UNIT_EN=4'b1000 only at T+1, ALU_FUN=2'b01, OUT_VALID at T+3, ALU_OUT=0x00004A52.
REQ-031 Timeout: req_fun=4'b0000 and no flag -> WAIT spans T+2..T+5, TIMEOUT_ERR at T+6, OUT_VALID stays 0, ALU_OUT unchanged, req_ready=1 at T+6.
REQ-032 Flag/timeout race: req_fun=4'b1000, flag at T+5 with CMP_OUT=0x1 -> OUT_VALID at T+6, ALU_OUT=0x00000001, TIMEOUT_ERR=0.
REQ-033 Wrong flag: req_fun=4'b0110, UNIT_FLAG=4'b1000 at T+2, then 4'b0010 at T+3 -> OUT_VALID at T+4 with the LOGIC_OUT value.
REQ-034 Back-to-back: req_valid held high with two operations -> req_ready=0 at T+1..T+2, second operation accepted at T+3.
REQ-035 Reset: RST=1 for one cycle at T+2, flag at T+3 -> at T+3 state is IDLE, UNIT_EN=0, ALU_OUT=0, and no OUT_VALID pulse follows.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the ALU operation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_t;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    function automatic int result_width(input int operand_width);
        return 2 * operand_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_timer.sv
// ============================================================================
// Module      : alu_seq_timer
// Description : WAIT-state watchdog; flags the last permitted wait cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_timer #(
    parameter int TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Count is 0 on the first running cycle; expired marks the final allowed one.
    assign expired = run && (r_count == c_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (run && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issues one request to an ALU sub-unit, waits for its flag with
//               a watchdog, and captures the selected result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 4
) (
    input  logic                              clk,
    input  logic                              RST,
    input  logic                              req_valid,
    input  logic [3:0]                        req_fun,
    output logic                              req_ready,
    output logic [3:0]                        UNIT_EN,
    output logic [1:0]                        ALU_FUN,
    input  logic [3:0]                        UNIT_FLAG,
    input  logic [result_width(WIDTH)-1:0]    ARITH_OUT,
    input  logic [result_width(WIDTH)-1:0]    LOGIC_OUT,
    input  logic [result_width(WIDTH)-1:0]    CMP_OUT,
    input  logic [result_width(WIDTH)-1:0]    SHIFT_OUT,
    output logic [result_width(WIDTH)-1:0]    ALU_OUT,
    output logic                              OUT_VALID,
    output logic                              TIMEOUT_ERR
);

    localparam int RW = result_width(WIDTH);

    seq_state_t      r_state;
    seq_state_t      w_next;
    logic [1:0]      r_sel;
    logic [1:0]      r_fun;
    logic [RW-1:0]   r_alu_out;
    logic            r_out_valid;
    logic            r_timeout_err;

    logic            w_accept;
    logic            w_flag;
    logic            w_capture;
    logic            w_timeout;
    logic            w_expired;
    logic [3:0]      w_unit_en;
    logic [RW-1:0]   w_sel_result;

    assign req_ready   = (r_state == S_IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_flag      = UNIT_FLAG[r_sel];
    assign UNIT_EN     = w_unit_en;
    assign ALU_FUN     = r_fun;
    assign ALU_OUT     = r_alu_out;
    assign OUT_VALID   = r_out_valid;
    assign TIMEOUT_ERR = r_timeout_err;

    alu_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (RST),
        .clear   (r_state != S_WAIT),
        .run     (r_state == S_WAIT),
        .expired (w_expired)
    );

    always_comb begin
        w_sel_result = ARITH_OUT;
        case (r_sel)
            UNIT_ARITH: w_sel_result = ARITH_OUT;
            UNIT_LOGIC: w_sel_result = LOGIC_OUT;
            UNIT_CMP:   w_sel_result = CMP_OUT;
            UNIT_SHIFT: w_sel_result = SHIFT_OUT;
            default:    w_sel_result = ARITH_OUT;
        endcase
    end

    always_comb begin
        w_unit_en = 4'b0000;
        if (r_state == S_ISSUE) begin
            w_unit_en[r_sel] = 1'b1;
        end
    end

    // Flag is tested before the watchdog so a late flag still wins the race.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_flag) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_sel         <= 2'b00;
            r_fun         <= 2'b00;
            r_alu_out     <= '0;
            r_out_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_out_valid   <= w_capture;
            r_timeout_err <= w_timeout;
            if (w_accept) begin
                r_sel <= req_fun[3:2];
                r_fun <= req_fun[1:0];
            end
            if (w_capture) begin
                r_alu_out <= w_sel_result;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed self-checking bench for alu_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 4;
    localparam int RW      = 2 * WIDTH;

    logic          clk;
    logic          RST;
    logic          req_valid;
    logic [3:0]    req_fun;
    logic          req_ready;
    logic [3:0]    UNIT_EN;
    logic [1:0]    ALU_FUN;
    logic [3:0]    UNIT_FLAG;
    logic [RW-1:0] ARITH_OUT;
    logic [RW-1:0] LOGIC_OUT;
    logic [RW-1:0] CMP_OUT;
    logic [RW-1:0] SHIFT_OUT;
    logic [RW-1:0] ALU_OUT;
    logic          OUT_VALID;
    logic          TIMEOUT_ERR;

    int errors = 0;
    int checks = 0;

    alu_op_sequencer #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_fun     (req_fun),
        .req_ready   (req_ready),
        .UNIT_EN     (UNIT_EN),
        .ALU_FUN     (ALU_FUN),
        .UNIT_FLAG   (UNIT_FLAG),
        .ARITH_OUT   (ARITH_OUT),
        .LOGIC_OUT   (LOGIC_OUT),
        .CMP_OUT     (CMP_OUT),
        .SHIFT_OUT   (SHIFT_OUT),
        .ALU_OUT     (ALU_OUT),
        .OUT_VALID   (OUT_VALID),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After tick, values reflect the cycle that just began; inputs set now are
    // sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (UNIT_EN !== 4'b0000) begin errors++; $display("FAIL reset_unit_en: got %b expected 0000", UNIT_EN); end
        checks++; if (ALU_FUN !== 2'b00) begin errors++; $display("FAIL reset_alu_fun: got %b expected 00", ALU_FUN); end
        checks++; if (ALU_OUT !== 32'h0) begin errors++; $display("FAIL reset_alu_out: got %h expected 00000000", ALU_OUT); end
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", TIMEOUT_ERR); end
    endtask

    task automatic test_shift();
        SHIFT_OUT = 32'h0000_4A52;
        ARITH_OUT = 32'hDEAD_0001;
        req_valid = 1'b1; req_fun = 4'b1101;                 // cycle T
        tick();                                              // T+1
        req_valid = 1'b0;
        checks++; if (UNIT_EN !== 4'b1000) begin errors++; $display("FAIL shift_unit_en_t1: got %b expected 1000", UNIT_EN); end
        checks++; if (ALU_FUN !== 2'b01) begin errors++; $display("FAIL shift_alu_fun: got %b expected 01", ALU_FUN); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL shift_ready_t1: got %b expected 0", req_ready); end
        tick();                                              // T+2
        checks++; if (UNIT_EN !== 4'b0000) begin errors++; $display("FAIL shift_unit_en_t2: got %b expected 0000", UNIT_EN); end
        UNIT_FLAG = 4'b1000;
        tick();                                              // T+3
        UNIT_FLAG = 4'b0000;
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL shift_out_valid: got %b expected 1", OUT_VALID); end
        checks++; if (ALU_OUT !== 32'h0000_4A52) begin errors++; $display("FAIL shift_alu_out: got %h expected 00004a52", ALU_OUT); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL shift_ready_t3: got %b expected 1", req_ready); end
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL shift_no_err: got %b expected 0", TIMEOUT_ERR); end
        tick();                                              // T+4
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL shift_pulse_len: got %b expected 0", OUT_VALID); end
        checks++; if (ALU_FUN !== 2'b01) begin errors++; $display("FAIL shift_fun_hold: got %b expected 01", ALU_FUN); end
    endtask

    task automatic test_timeout();
        ARITH_OUT = 32'h1111_2222;
        req_valid = 1'b1; req_fun = 4'b0000;                 // T
        tick();                                              // T+1
        req_valid = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();                                          // T+2..T+5
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL timeout_wait_ready_t%0d: got %b expected 0", c, req_ready); end
            checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL timeout_early_err_t%0d: got %b expected 0", c, TIMEOUT_ERR); end
        end
        tick();                                              // T+6
        checks++; if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", TIMEOUT_ERR); end
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL timeout_out_valid: got %b expected 0", OUT_VALID); end
        checks++; if (ALU_OUT !== 32'h0000_4A52) begin errors++; $display("FAIL timeout_alu_out: got %h expected 00004a52", ALU_OUT); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b expected 1", req_ready); end
        tick();                                              // T+7
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL timeout_pulse_len: got %b expected 0", TIMEOUT_ERR); end
    endtask

    task automatic test_race();
        CMP_OUT = 32'h0000_0001;
        req_valid = 1'b1; req_fun = 4'b1000;                 // T
        tick();                                              // T+1
        req_valid = 1'b0;
        tick(); tick(); tick();                              // T+4
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL race_early_valid: got %b expected 0", OUT_VALID); end
        tick();                                              // T+5
        UNIT_FLAG = 4'b0100;
        tick();                                              // T+6
        UNIT_FLAG = 4'b0000;
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL race_out_valid: got %b expected 1", OUT_VALID); end
        checks++; if (ALU_OUT !== 32'h0000_0001) begin errors++; $display("FAIL race_alu_out: got %h expected 00000001", ALU_OUT); end
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL race_err: got %b expected 0", TIMEOUT_ERR); end
        tick();                                              // T+7
        checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL race_err_late: got %b expected 0", TIMEOUT_ERR); end
    endtask

    task automatic test_wrong_flag();
        LOGIC_OUT = 32'h1234_5678;
        SHIFT_OUT = 32'h8765_4321;
        req_valid = 1'b1; req_fun = 4'b0110;                 // T
        tick();                                              // T+1
        req_valid = 1'b0;
        checks++; if (UNIT_EN !== 4'b0010) begin errors++; $display("FAIL wrong_unit_en: got %b expected 0010", UNIT_EN); end
        tick();                                              // T+2
        UNIT_FLAG = 4'b1000;
        tick();                                              // T+3
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL wrong_flag_ignored: got %b expected 0", OUT_VALID); end
        UNIT_FLAG = 4'b0010;
        tick();                                              // T+4
        UNIT_FLAG = 4'b0000;
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL wrong_out_valid: got %b expected 1", OUT_VALID); end
        checks++; if (ALU_OUT !== 32'h1234_5678) begin errors++; $display("FAIL wrong_alu_out: got %h expected 12345678", ALU_OUT); end
        checks++; if (ALU_FUN !== 2'b10) begin errors++; $display("FAIL wrong_alu_fun: got %b expected 10", ALU_FUN); end
        tick();
    endtask

    task automatic test_back_to_back();
        ARITH_OUT = 32'hA5A5_0F0F;
        LOGIC_OUT = 32'h0000_00C3;
        req_valid = 1'b1; req_fun = 4'b0001;                 // T
        tick();                                              // T+1
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t1: got %b expected 0", req_ready); end
        tick();                                              // T+2
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t2: got %b expected 0", req_ready); end
        UNIT_FLAG = 4'b0001;
        tick();                                              // T+3
        UNIT_FLAG = 4'b0000;
        req_fun = 4'b0111;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t3: got %b expected 1", req_ready); end
        checks++; if (ALU_OUT !== 32'hA5A5_0F0F) begin errors++; $display("FAIL b2b_first_out: got %h expected a5a50f0f", ALU_OUT); end
        tick();                                              // T+4
        req_valid = 1'b0;
        checks++; if (UNIT_EN !== 4'b0010) begin errors++; $display("FAIL b2b_second_en: got %b expected 0010", UNIT_EN); end
        checks++; if (ALU_FUN !== 2'b11) begin errors++; $display("FAIL b2b_second_fun: got %b expected 11", ALU_FUN); end
        tick();                                              // T+5
        UNIT_FLAG = 4'b0010;
        tick();                                              // T+6
        UNIT_FLAG = 4'b0000;
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b expected 1", OUT_VALID); end
        checks++; if (ALU_OUT !== 32'h0000_00C3) begin errors++; $display("FAIL b2b_second_out: got %h expected 000000c3", ALU_OUT); end
        tick();
    endtask

    task automatic test_reset_abort();
        ARITH_OUT = 32'h7777_7777;
        req_valid = 1'b1; req_fun = 4'b0000;                 // T
        tick();                                              // T+1
        req_valid = 1'b0;
        tick();                                              // T+2
        RST = 1'b1;
        tick();                                              // T+3
        RST = 1'b0;
        UNIT_FLAG = 4'b0001;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b expected 1", req_ready); end
        checks++; if (UNIT_EN !== 4'b0000) begin errors++; $display("FAIL abort_unit_en: got %b expected 0000", UNIT_EN); end
        checks++; if (ALU_OUT !== 32'h0) begin errors++; $display("FAIL abort_alu_out: got %h expected 00000000", ALU_OUT); end
        checks++; if (ALU_FUN !== 2'b00) begin errors++; $display("FAIL abort_alu_fun: got %b expected 00", ALU_FUN); end
        for (int c = 4; c <= 8; c++) begin
            tick();
            UNIT_FLAG = 4'b0000;
            checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL abort_no_valid_t%0d: got %b expected 0", c, OUT_VALID); end
            checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL abort_no_err_t%0d: got %b expected 0", c, TIMEOUT_ERR); end
        end
        checks++; if (ALU_OUT !== 32'h0) begin errors++; $display("FAIL abort_alu_out_late: got %h expected 00000000", ALU_OUT); end
    endtask

    initial begin
        RST       = 1'b0;
        req_valid = 1'b0;
        req_fun   = 4'b0000;
        UNIT_FLAG = 4'b0000;
        ARITH_OUT = '0;
        LOGIC_OUT = '0;
        CMP_OUT   = '0;
        SHIFT_OUT = '0;
        tick();
        test_reset();
        test_shift();
        test_timeout();
        test_race();
        test_wrong_flag();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
